// File: rtl/zap_branch_predictor_table_pkg.sv
// Shared branch-state and sweep-FSM encodings for the predictor table and predecode.
// Also holds the 2-bit saturating counter training function.
package zap_branch_predictor_table_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bp_state_e;

  typedef enum logic {
    FSM_INIT  = 1'b0,
    FSM_READY = 1'b1
  } bp_fsm_e;

  localparam int PC_W = 32;

  // Train from the state carried down the pipe; AL branches jump straight to ST.
  function automatic logic [1:0] bp_train(input logic [1:0] st,
                                          input logic       taken,
                                          input logic       always_taken);
    logic [1:0] nxt;
    if (always_taken)   nxt = ST;
    else if (taken)     nxt = (st == ST)  ? st : st + 2'd1;
    else                nxt = (st == SNT) ? st : st - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/zap_branch_predictor_table_if.sv
// Fetch/predecode/ALU-facing bundle of the branch predictor table.
// The master side is the pipeline; the slave side is the predictor.
interface zap_branch_predictor_table_if;
  import zap_branch_predictor_table_pkg::*;

  logic            i_flush;
  logic            i_lookup_valid;
  logic [PC_W-1:0] i_lookup_pc;
  logic            i_stall;
  logic            i_clear;
  logic            i_upd_valid;
  logic [PC_W-1:0] i_upd_pc;
  logic [1:0]      i_upd_state;
  logic            i_upd_taken;
  logic            i_upd_always;
  logic [1:0]      o_taken_ff;
  logic            o_busy;

  modport master (
    output i_flush, i_lookup_valid, i_lookup_pc, i_stall, i_clear,
           i_upd_valid, i_upd_pc, i_upd_state, i_upd_taken, i_upd_always,
    input  o_taken_ff, o_busy
  );

  modport slave (
    input  i_flush, i_lookup_valid, i_lookup_pc, i_stall, i_clear,
           i_upd_valid, i_upd_pc, i_upd_state, i_upd_taken, i_upd_always,
    output o_taken_ff, o_busy
  );

endinterface

// File: rtl/zap_bp_ram.sv
// ENTRIES x 2-bit counter storage: one synchronous write port, one asynchronous read port.
// Contents are initialised by the owner's sweep, not by reset.
module zap_bp_ram #(
  parameter int ENTRIES = 256,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [1:0]       i_wdata,
  input  logic [IDX_W-1:0] i_raddr,
  output logic [1:0]       o_rdata
);

  logic [1:0] r_mem [ENTRIES];

  // NOTE: storage arrays carry no reset; a reset here would fan out to every flop,
  // and the sweep FSM guarantees defined contents before any read is trusted.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/zap_branch_predictor_table.sv
// Dynamic branch predictor: 2-bit saturating counters indexed by PC, cleared by a sweep FSM
// after reset/flush, trained from ALU resolution with a write-first bypass to lookups.
module zap_branch_predictor_table
  import zap_branch_predictor_table_pkg::*;
#(
  parameter int        ENTRIES = 256,
  parameter int        PC_LSB  = 1,
  parameter bp_state_e INIT_ST = WNT
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  zap_branch_predictor_table_if.slave  bp
);

  localparam int               IDX_W    = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  bp_fsm_e          r_fsm;
  bp_fsm_e          w_fsm_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;

  logic [IDX_W-1:0] w_lk_idx;
  logic [IDX_W-1:0] w_upd_idx;
  logic [1:0]       w_upd_new;
  logic             w_upd_we;

  logic             w_ram_we;
  logic [IDX_W-1:0] w_ram_waddr;
  logic [1:0]       w_ram_wdata;
  logic [1:0]       w_ram_rdata;
  logic [1:0]       w_lookup_st;

  // Upper PC bits deliberately alias; fold them so the unused bits are accounted for.
  logic             w_unused_pc;
  assign w_unused_pc = ^{bp.i_lookup_pc, bp.i_upd_pc};

  assign w_lk_idx  = bp.i_lookup_pc[PC_LSB +: IDX_W];
  assign w_upd_idx = bp.i_upd_pc[PC_LSB +: IDX_W];
  assign w_upd_new = bp_train(bp.i_upd_state, bp.i_upd_taken, bp.i_upd_always);

  // Updates only land when the table is live and no flush is discarding them.
  assign w_upd_we  = (r_fsm == FSM_READY) && bp.i_upd_valid && !bp.i_flush;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_fsm <= FSM_INIT;
      r_ptr <= '0;
    end else begin
      r_fsm <= w_fsm_nxt;
      r_ptr <= w_ptr_nxt;
    end
  end

  // NOTE: every output of this block is given a default first so no path infers a latch.
  always_comb begin
    w_fsm_nxt = r_fsm;
    w_ptr_nxt = r_ptr;
    case (r_fsm)
      FSM_INIT: begin
        if (bp.i_flush) begin
          w_ptr_nxt = '0;
        end else if (r_ptr == LAST_IDX) begin
          w_fsm_nxt = FSM_READY;
          w_ptr_nxt = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
        end
      end
      FSM_READY: begin
        if (bp.i_flush) begin
          w_fsm_nxt = FSM_INIT;
          w_ptr_nxt = '0;
        end
      end
      default: begin
        w_fsm_nxt = FSM_INIT;
        w_ptr_nxt = '0;
      end
    endcase
  end

  // Single write port shared between the init sweep and branch training.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = w_upd_idx;
    w_ram_wdata = w_upd_new;
    if (r_fsm == FSM_INIT) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = r_ptr;
      w_ram_wdata = INIT_ST;
    end else if (w_upd_we) begin
      w_ram_we    = 1'b1;
    end
  end

  zap_bp_ram #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_lk_idx),
    .o_rdata (w_ram_rdata)
  );

  // During the sweep the array is only partly initialised, so report INIT_ST directly.
  always_comb begin
    w_lookup_st = w_ram_rdata;
    if (r_fsm == FSM_INIT)                            w_lookup_st = INIT_ST;
    else if (w_upd_we && (w_upd_idx == w_lk_idx))     w_lookup_st = w_upd_new;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)              bp.o_taken_ff <= 2'd0;
    else if (bp.i_clear)         bp.o_taken_ff <= 2'd0;
    else if (bp.i_stall)         bp.o_taken_ff <= bp.o_taken_ff;
    else if (bp.i_lookup_valid)  bp.o_taken_ff <= w_lookup_st;
    else                         bp.o_taken_ff <= 2'd0;
  end

  assign bp.o_busy = (r_fsm == FSM_INIT);

endmodule
